control_estado_mascota: RTL and testbench

Supervisory controller above the four mode counters (ánimo, energía, descanso, medicina). It reads their 2-bit levels and picks one global pet state (face) for the display driver. It gates the feed and medicine enables back into the energy and medicine modes. It also sequences a face scan while test mode is held.

---
 rtl/pet_pkg.sv | 50 +++++
 rtl/contador_enfriamiento.sv | 46 ++++
 rtl/control_estado_mascota.sv | 157 +++++++++++++++
 tb/tb_control_estado_mascota.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// Shared definitions for the pet supervisory controller.
// Face codes driven to the display, mode-level width and range, the
// supervisory FSM mode type and the candidate-face priority function.
package pet_pkg;

  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned FACE_W  = 3;

  localparam logic [LEVEL_W-1:0] MAX_LEVEL = 2'd3;
  localparam logic [LEVEL_W-1:0] MID_LEVEL = 2'd2;

  localparam logic [FACE_W-1:0] FELIZ      = 3'd0;
  localparam logic [FACE_W-1:0] NEUTRO     = 3'd1;
  localparam logic [FACE_W-1:0] TRISTE     = 3'd2;
  localparam logic [FACE_W-1:0] CANSADO    = 3'd3;
  localparam logic [FACE_W-1:0] HAMBRIENTO = 3'd4;
  localparam logic [FACE_W-1:0] ENFERMO    = 3'd5;

  typedef enum logic {
    NORMAL = 1'b0,
    TEST   = 1'b1
  } modo_t;

  // Face the levels are asking for; health outranks hunger, hunger outranks
  // tiredness, tiredness outranks sadness.
  function automatic logic [FACE_W-1:0] candidato(
    input logic [LEVEL_W-1:0] animo,
    input logic [LEVEL_W-1:0] energia,
    input logic [LEVEL_W-1:0] descanso,
    input logic [LEVEL_W-1:0] medicina
  );
    logic [FACE_W-1:0] c;
    if (medicina == 2'd0) begin
      c = ENFERMO;
    end else if (energia == 2'd0) begin
      c = HAMBRIENTO;
    end else if (descanso == 2'd0) begin
      c = CANSADO;
    end else if (animo == 2'd0) begin
      c = TRISTE;
    end else if ((animo >= MID_LEVEL) && (energia >= MID_LEVEL) &&
                 (descanso >= MID_LEVEL) && (medicina >= MID_LEVEL)) begin
      c = FELIZ;
    end else begin
      c = NEUTRO;
    end
    return c;
  endfunction

endpackage

// File: rtl/contador_enfriamiento.sv
// Loadable saturating down-counter used as a feed/medicine cooldown.
// Ports:
//   clk    system clock
//   reset  synchronous active-low reset (count cleared)
//   carga  reload the count with MAX at the next edge
//   cero   high when the count after the next edge will be zero
module contador_enfriamiento
  #(parameter int unsigned MAX = 100000000)
(
  input  logic clk,
  input  logic reset,
  input  logic carga,
  output logic cero
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cuenta_r;
  logic [W-1:0] cuenta_next_s;

  // Next count: a reload wins, otherwise step down and hold at zero.
  always_comb begin
    cuenta_next_s = cuenta_r;
    if (carga) begin
      cuenta_next_s = W'(MAX);
    end else if (cuenta_r != '0) begin
      cuenta_next_s = cuenta_r - W'(1);
    end else begin
      cuenta_next_s = '0;
    end
  end

  // Zero flag looks at the upcoming count so the owner can register an
  // enable that drops on the very edge the reload happens.
  assign cero = (cuenta_next_s == '0);

  // Count register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cuenta_r <= '0;
    end else begin
      cuenta_r <= cuenta_next_s;
    end
  end

endmodule

// File: rtl/control_estado_mascota.sv
// Supervisory controller for the virtual pet.
// Reads the four mode levels, debounces the wanted face through a stability
// window, gates feed/medicine enables with cooldowns and runs a face scan
// while test mode is held.
// Ports:
//   clk, reset                   clock, synchronous active-low reset
//   nivel_animo/energia/descanso/medicina  2-bit mode levels
//   test_activo                  debounced test-mode level
//   cara                         face code to the display
//   activo_comida/medicina       enables back to energy/medicine modes
//   alarma                       one-cycle pulse on entering ENFERMO/HAMBRIENTO
//   en_test                      high while in test mode
module control_estado_mascota
  import pet_pkg::*;
#(
  parameter int unsigned DWELL     = 250000000,
  parameter int unsigned TEST_STEP = 50000000,
  parameter int unsigned COOLDOWN  = 100000000
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] nivel_animo,
  input  logic [LEVEL_W-1:0] nivel_energia,
  input  logic [LEVEL_W-1:0] nivel_descanso,
  input  logic [LEVEL_W-1:0] nivel_medicina,
  input  logic               test_activo,
  output logic [FACE_W-1:0]  cara,
  output logic               activo_comida,
  output logic               activo_medicina,
  output logic               alarma,
  output logic               en_test
);

  localparam int unsigned DW_W = $clog2(DWELL + 1);
  localparam int unsigned TS_W = $clog2(TEST_STEP + 1);
  localparam logic [DW_W-1:0] DWELL_FIN = DW_W'(DWELL - 1);
  localparam logic [TS_W-1:0] PASO_FIN  = TS_W'(TEST_STEP - 1);

  modo_t               modo_r, modo_next_s;
  logic [FACE_W-1:0]   estado_r, estado_next_s;
  logic [FACE_W-1:0]   cand_s, cand_prev_r;
  logic [DW_W-1:0]     dwell_r, dwell_next_s, dwell_run_s;
  logic [TS_W-1:0]     paso_r, paso_next_s;
  logic [FACE_W-1:0]   cara_next_s;
  logic                alarma_next_s, comida_next_s, medicina_next_s;
  logic                test_prev_r;
  logic [LEVEL_W-1:0]  energia_prev_r, medicina_prev_r;
  logic                sube_energia_s, sube_medicina_s;
  logic                cero_comida_s, cero_medicina_s;

  assign cand_s          = candidato(nivel_animo, nivel_energia, nivel_descanso, nivel_medicina);
  assign sube_energia_s  = (nivel_energia > energia_prev_r);
  assign sube_medicina_s = (nivel_medicina > medicina_prev_r);

  contador_enfriamiento #(.MAX(COOLDOWN)) u_enfr_comida (
    .clk   (clk),
    .reset (reset),
    .carga (sube_energia_s),
    .cero  (cero_comida_s)
  );

  contador_enfriamiento #(.MAX(COOLDOWN)) u_enfr_medicina (
    .clk   (clk),
    .reset (reset),
    .carga (sube_medicina_s),
    .cero  (cero_medicina_s)
  );

  // Next mode, committed face, dwell/scan counters and output values.
  always_comb begin
    modo_next_s   = modo_r;
    estado_next_s = estado_r;
    dwell_next_s  = '0;
    paso_next_s   = paso_r;
    cara_next_s   = cara;
    alarma_next_s = 1'b0;
    // dwell_run_s counts stable samples minus one; a new candidate restarts it.
    dwell_run_s   = (cand_s != cand_prev_r) ? '0 : (dwell_r + DW_W'(1));
    case (modo_r)
      NORMAL: begin
        if (test_activo && !test_prev_r) begin
          // Test entry outranks any commit landing on the same edge.
          modo_next_s = TEST;
          paso_next_s = '0;
          cara_next_s = FELIZ;
        end else if (cand_s == estado_r) begin
          dwell_next_s = '0;
          cara_next_s  = estado_r;
        end else if (dwell_run_s == DWELL_FIN) begin
          estado_next_s = cand_s;
          dwell_next_s  = '0;
          cara_next_s   = cand_s;
          alarma_next_s = (cand_s == ENFERMO) || (cand_s == HAMBRIENTO);
        end else begin
          dwell_next_s = dwell_run_s;
          cara_next_s  = estado_r;
        end
      end
      TEST: begin
        if (!test_activo) begin
          // Leaving test restarts evaluation from NEUTRO with a fresh dwell.
          modo_next_s   = NORMAL;
          estado_next_s = NEUTRO;
          cara_next_s   = NEUTRO;
          paso_next_s   = '0;
        end else if (paso_r == PASO_FIN) begin
          paso_next_s = '0;
          cara_next_s = (cara == ENFERMO) ? FELIZ : (cara + 3'd1);
        end else begin
          paso_next_s = paso_r + TS_W'(1);
        end
      end
      default: begin
        modo_next_s   = NORMAL;
        estado_next_s = NEUTRO;
        cara_next_s   = NEUTRO;
        paso_next_s   = '0;
      end
    endcase
    comida_next_s   = (nivel_energia < MAX_LEVEL) && cero_comida_s && (modo_next_s == NORMAL);
    medicina_next_s = (nivel_medicina < MAX_LEVEL) && cero_medicina_s && (modo_next_s == NORMAL);
  end

  // State, history and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      modo_r          <= NORMAL;
      estado_r        <= NEUTRO;
      cand_prev_r     <= NEUTRO;
      dwell_r         <= '0;
      paso_r          <= '0;
      test_prev_r     <= test_activo;
      energia_prev_r  <= nivel_energia;
      medicina_prev_r <= nivel_medicina;
      cara            <= NEUTRO;
      alarma          <= 1'b0;
      activo_comida   <= 1'b0;
      activo_medicina <= 1'b0;
      en_test         <= 1'b0;
    end else begin
      modo_r          <= modo_next_s;
      estado_r        <= estado_next_s;
      cand_prev_r     <= cand_s;
      dwell_r         <= dwell_next_s;
      paso_r          <= paso_next_s;
      test_prev_r     <= test_activo;
      energia_prev_r  <= nivel_energia;
      medicina_prev_r <= nivel_medicina;
      cara            <= cara_next_s;
      alarma          <= alarma_next_s;
      activo_comida   <= comida_next_s;
      activo_medicina <= medicina_next_s;
      en_test         <= (modo_next_s == TEST);
    end
  end

endmodule

// File: tb/tb_control_estado_mascota.sv
// Self-checking bench for control_estado_mascota with small timing parameters.
// A behavioural model tracks how long each candidate face has been seen,
// remaining cooldown cycles and time spent in test mode.
module tb_control_estado_mascota;

  localparam int DWELL     = 4;
  localparam int TEST_STEP = 3;
  localparam int COOLDOWN  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] animo, energia, descanso, medicina;
  logic       test_activo;
  logic [2:0] cara;
  logic       activo_comida, activo_medicina, alarma, en_test;

  int total = 0;
  int bad   = 0;

  // model state
  int m_cara, m_committed, m_last, m_run, m_age, m_cd_e, m_cd_m, m_pe, m_pm;
  bit m_test, m_alarma, m_comida, m_med, m_pt;

  always #5 clk = ~clk;

  control_estado_mascota #(.DWELL(DWELL), .TEST_STEP(TEST_STEP), .COOLDOWN(COOLDOWN)) dut (
    .clk             (clk),
    .reset           (reset),
    .nivel_animo     (animo),
    .nivel_energia   (energia),
    .nivel_descanso  (descanso),
    .nivel_medicina  (medicina),
    .test_activo     (test_activo),
    .cara            (cara),
    .activo_comida   (activo_comida),
    .activo_medicina (activo_medicina),
    .alarma          (alarma),
    .en_test         (en_test)
  );

  function automatic int cand_of(int a, int e, int d, int m);
    if (m == 0) return 5;
    if (e == 0) return 4;
    if (d == 0) return 3;
    if (a == 0) return 2;
    if (a >= 2 && e >= 2 && d >= 2 && m >= 2) return 0;
    return 1;
  endfunction

  function automatic logic [6:0] expected();
    return {3'(m_cara), m_alarma, m_comida, m_med, m_test};
  endfunction

  function automatic logic [6:0] observed();
    return {cara, alarma, activo_comida, activo_medicina, en_test};
  endfunction

  task automatic model_step();
    int c;
    if (!reset) begin
      m_test = 0; m_committed = 1; m_cara = 1; m_alarma = 0;
      m_comida = 0; m_med = 0; m_last = -1; m_run = 0; m_age = 0;
      m_cd_e = 0; m_cd_m = 0;
      m_pe = int'(energia); m_pm = int'(medicina); m_pt = test_activo;
      return;
    end
    c = cand_of(int'(animo), int'(energia), int'(descanso), int'(medicina));
    m_run  = (c == m_last) ? m_run + 1 : 1;
    m_last = c;
    m_cd_e = (int'(energia) > m_pe) ? COOLDOWN : ((m_cd_e > 0) ? m_cd_e - 1 : 0);
    m_cd_m = (int'(medicina) > m_pm) ? COOLDOWN : ((m_cd_m > 0) ? m_cd_m - 1 : 0);
    m_alarma = 0;
    if (!m_test) begin
      if (test_activo && !m_pt) begin
        m_test = 1; m_age = 0; m_cara = 0;
      end else begin
        if (c != m_committed && m_run >= DWELL) begin
          m_committed = c;
          m_alarma = (c == 4 || c == 5);
        end
        m_cara = m_committed;
      end
    end else if (!test_activo) begin
      m_test = 0; m_committed = 1; m_cara = 1; m_run = 1;
    end else begin
      m_age++;
      m_cara = (m_age / TEST_STEP) % 6;
    end
    m_comida = (energia < 2'd3) && (m_cd_e == 0) && !m_test;
    m_med    = (medicina < 2'd3) && (m_cd_m == 0) && !m_test;
    m_pe = int'(energia); m_pm = int'(medicina); m_pt = test_activo;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; animo = 2'd3; energia = 2'd3; descanso = 2'd3; medicina = 2'd3;
    test_activo = 1'b0;
    tick(); tick();
    total++;
    if (observed() !== 7'b001_0000) begin
      bad++; $display("FAIL reset_values: got %b want %b", observed(), 7'b001_0000);
    end
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL reset_release_model k=%0d: got %b want %b", k, observed(), expected());
      end
      if (k == 2) begin
        total++;
        if (cara !== 3'd1) begin bad++; $display("FAIL reset_hold_neutro: got %0d want 1", cara); end
      end
      if (k == 4) begin
        total++;
        if (cara !== 3'd0) begin bad++; $display("FAIL reset_to_feliz: got %0d want 0", cara); end
      end
      total++;
      if (alarma !== 1'b0) begin bad++; $display("FAIL reset_no_alarma k=%0d: got %b want 0", k, alarma); end
    end
  endtask

  task automatic test_alarma();
    medicina = 2'd0; energia = 2'd0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL alarma_model k=%0d: got %b want %b", k, observed(), expected());
      end
      total++;
      if (k < 4 && (cara !== 3'd0)) begin
        bad++; $display("FAIL alarma_early k=%0d: got %0d want 0", k, cara);
      end else if (k == 4 && ({cara, alarma} !== {3'd5, 1'b1})) begin
        bad++; $display("FAIL alarma_enfermo: got cara=%0d alarma=%b want 5 1", cara, alarma);
      end else if (k == 5 && ({cara, alarma} !== {3'd5, 1'b0})) begin
        bad++; $display("FAIL alarma_single: got cara=%0d alarma=%b want 5 0", cara, alarma);
      end
    end
  endtask

  task automatic test_flicker();
    animo = 2'd3; energia = 2'd3; descanso = 2'd3; medicina = 2'd3;
    repeat (8) tick();
    total++;
    if (cara !== 3'd0) begin bad++; $display("FAIL flicker_start: got %0d want 0", cara); end
    energia = 2'd0; tick(); tick();
    energia = 2'd1; tick();
    energia = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL flicker_model k=%0d: got %b want %b", k, observed(), expected());
      end
      total++;
      if (cara !== ((k == 4) ? 3'd4 : 3'd0)) begin
        bad++; $display("FAIL flicker_commit k=%0d: got %0d want %0d", k, cara, (k == 4) ? 4 : 0);
      end
    end
  endtask

  task automatic test_cooldown();
    energia = 2'd1; repeat (8) tick();
    total++;
    if (activo_comida !== 1'b1) begin bad++; $display("FAIL cooldown_idle: got %b want 1", activo_comida); end
    energia = 2'd2;
    for (int k = 0; k <= 6; k++) begin
      tick();
      total++;
      if (activo_comida !== (k >= 5)) begin
        bad++; $display("FAIL cooldown_single k=%0d: got %b want %b", k, activo_comida, k >= 5);
      end
    end
    energia = 2'd0; repeat (6) tick();
    energia = 2'd1;
    for (int k = 0; k <= 9; k++) begin
      if (k == 3) energia = 2'd2;
      tick();
      total++;
      if (activo_comida !== (k >= 8)) begin
        bad++; $display("FAIL cooldown_reload k=%0d: got %b want %b", k, activo_comida, k >= 8);
      end
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL cooldown_model k=%0d: got %b want %b", k, observed(), expected());
      end
    end
  endtask

  task automatic test_scan();
    animo = 2'd2; energia = 2'd2; descanso = 2'd1; medicina = 2'd3;
    tick();
    test_activo = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      tick();
      total++;
      if ({cara, activo_comida, activo_medicina, en_test, alarma} !== {3'((k / 3) % 6), 4'b0010}) begin
        bad++; $display("FAIL scan k=%0d: got cara=%0d en=%b%b test=%b al=%b want cara=%0d 0 0 1 0",
                        k, cara, activo_comida, activo_medicina, en_test, alarma, (k / 3) % 6);
      end
    end
    test_activo = 1'b0;
    tick();
    total++;
    if ({cara, en_test} !== {3'd1, 1'b0}) begin
      bad++; $display("FAIL scan_exit: got cara=%0d test=%b want 1 0", cara, en_test);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL scan_redwell k=%0d: got %b want %b", k, observed(), expected());
      end
    end
  endtask

  task automatic test_back_to_back();
    animo = 2'd3; energia = 2'd3; descanso = 2'd3; medicina = 2'd3;
    repeat (8) tick();
    energia = 2'd0;
    tick(); tick(); tick();
    test_activo = 1'b1;
    tick();
    total++;
    if ({cara, alarma, en_test} !== {3'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL b2b_test_wins: got cara=%0d al=%b test=%b want 0 0 1", cara, alarma, en_test);
    end
    tick();
    test_activo = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL b2b_model k=%0d: got %b want %b", k, observed(), expected());
      end
    end
  endtask

  task automatic test_reset_mid();
    energia = 2'd1; test_activo = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++;
    if (observed() !== 7'b001_0000) begin
      bad++; $display("FAIL reset_mid: got %b want %b", observed(), 7'b001_0000);
    end
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (en_test !== 1'b0 || observed() !== expected()) begin
        bad++; $display("FAIL reset_mid_no_test k=%0d: got %b want %b", k, observed(), expected());
      end
    end
    test_activo = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: animo    = 2'($urandom_range(0, 3));
          1: energia  = 2'($urandom_range(0, 3));
          2: descanso = 2'($urandom_range(0, 3));
          default: medicina = 2'($urandom_range(0, 3));
        endcase
      end
      if ($urandom_range(0, 39) == 0) test_activo = ~test_activo;
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL random k=%0d: got %b want %b", k, observed(), expected());
      end
    end
    reset = 1'b1; test_activo = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alarma();
    test_flicker();
    test_cooldown();
    test_scan();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
